// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, write port,
// scoreboard set and clear-engine handshake.
interface reg_file_mp_if #(
  parameter int DATA_W   = 19,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    output sb_set, sb_addr, clr_req,
    input  rd_data, rd_pending, clr_busy, clr_done
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    input  sb_set, sb_addr, clr_req,
    output rd_data, rd_pending, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, write bypass,
// pending scoreboard and a one-entry-per-cycle clear engine.
module reg_file_mp #(
  parameter int DATA_W   = 19,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_mp_if.slave bus
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(NUM_REGS);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  state_e              state_q;
  state_e              state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   idx_d;
  logic                busy_q;
  logic                busy_d;
  logic                done_q;
  logic                done_d;
  logic                wr_ok;
  logic                sb_ok;

  assign wr_ok = bus.wr_en && in_range(bus.wr_addr)
               && !is_zero(bus.wr_addr);
  assign sb_ok = bus.sb_set && in_range(bus.sb_addr)
               && !is_zero(bus.sb_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Engine clear goes first so a same-cycle user write overrides it,
  // and the scoreboard set goes last so it beats a same-cycle write.
  always_comb begin
    regs_d  = regs_q;
    pend_d  = pend_q;
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
          pend_d  = '0;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = '0;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ok) begin
      regs_d[bus.wr_addr] = bus.wr_data;
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (sb_ok) pend_d[bus.sb_addr] = 1'b1;
    busy_d = (state_d == CLEAR);
  end

  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_pend_w;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              blank;
    logic              byp;
    assign a     = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign blank = is_zero(a) || !in_range(a);
    assign byp   = (BYPASS != 0) && wr_ok && (bus.wr_addr == a);
    assign rd_data_w[p*DATA_W +: DATA_W] =
      blank ? '0 : (byp ? bus.wr_data : regs_q[a]);
    assign rd_pend_w[p] = !blank && !byp && pend_q[a];
  end

  assign bus.rd_data    = rd_data_w;
  assign bus.rd_pending = rd_pend_w;
  assign bus.clr_busy   = busy_q;
  assign bus.clr_done   = done_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a bypassing instance and a
// non-bypassing twin driven with the same stimulus.
module tb_reg_file_mp;

  localparam int DW = 19;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;

  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2)) bus ();
  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2)) nb ();

  assign nb.rd_addr = bus.rd_addr;
  assign nb.wr_en   = bus.wr_en;
  assign nb.wr_addr = bus.wr_addr;
  assign nb.wr_data = bus.wr_data;
  assign nb.sb_set  = bus.sb_set;
  assign nb.sb_addr = bus.sb_addr;
  assign nb.clr_req = bus.clr_req;

  reg_file_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2),
    .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  reg_file_mp #(
    .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(2),
    .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk),
    .rst(rst),
    .bus(nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [DW-1:0] mregs [NR];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return 32'(bus.rd_data[0 +: DW]);
      1: return 32'(bus.rd_data[DW +: DW]);
      2: return 32'(bus.rd_pending[0]);
      3: return 32'(bus.rd_pending[1]);
      4: return 32'(bus.clr_busy);
      5: return 32'(bus.clr_done);
      6: return 32'(nb.rd_data[0 +: DW]);
      7: return 32'(nb.rd_pending[0]);
      default: return 32'hDEAD;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel,
                          input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle_in();
    bus.wr_en   = 1'b0;
    bus.sb_set  = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
  endtask

  task automatic rd(input int a0, input int a1);
    bus.rd_addr = {AW'(a1), AW'(a0)};
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    rst = 1'b1;
    bus.rd_addr = '0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.sb_set = 1'b0;
    bus.sb_addr = '0;
    bus.clr_req = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;

    expect_v("rst_d0", 0, 0);
    expect_v("rst_d1", 1, 0);
    expect_v("rst_p0", 2, 0);
    expect_v("rst_busy", 4, 0);
    expect_v("rst_done", 5, 0);
    drain();

    @(negedge clk); rst = 1'b0;
    @(negedge clk); wr(5, 19'h7FFFF);
    drain();
    @(negedge clk); idle_in(); rd(5, 5);
    expect_v("r5_p0", 0, 32'h7FFFF);
    expect_v("r5_p1", 1, 32'h7FFFF);
    expect_v("r5_pend", 2, 0);
    drain();
    @(negedge clk); rd(5, 6);
    expect_v("r6_p1", 1, 0);
    drain();

    @(negedge clk); wr(0, 19'h12345); rd(0, 0);
    expect_v("r0_wr_byp", 0, 0);
    drain();
    @(negedge clk); idle_in(); bus.sb_set = 1'b1; bus.sb_addr = '0;
    expect_v("r0_read", 0, 0);
    drain();
    @(negedge clk); idle_in();
    expect_v("r0_pend", 2, 0);
    drain();

    @(negedge clk); wr(7, 19'h11111);
    drain();
    @(negedge clk); idle_in(); bus.sb_set = 1'b1; bus.sb_addr = 5'd7;
    drain();
    @(negedge clk); idle_in(); wr(7, 19'h00ABC); rd(7, 5);
    expect_v("byp_data", 0, 32'h00ABC);
    expect_v("byp_pend", 2, 0);
    expect_v("nobyp_data", 6, 32'h11111);
    expect_v("nobyp_pend", 7, 1);
    drain();
    @(negedge clk); idle_in();
    expect_v("r7_after", 0, 32'h00ABC);
    expect_v("r7_nb_after", 6, 32'h00ABC);
    drain();

    @(negedge clk); bus.sb_set = 1'b1; bus.sb_addr = 5'd3; rd(3, 3);
    expect_v("sb3_same", 2, 0);
    drain();
    @(negedge clk); idle_in();
    expect_v("sb3_next", 2, 1);
    expect_v("sb3_next_p1", 3, 1);
    drain();
    @(negedge clk); wr(3, 19'h00001); rd(7, 7);
    drain();
    @(negedge clk); idle_in(); rd(3, 3);
    expect_v("wr3_pend", 2, 0);
    expect_v("wr3_data", 0, 1);
    drain();
    @(negedge clk); wr(3, 19'h00002); bus.sb_set = 1'b1;
    bus.sb_addr = 5'd3; rd(5, 5);
    drain();
    @(negedge clk); idle_in(); rd(3, 3);
    expect_v("both3_pend", 2, 1);
    expect_v("both3_data", 0, 2);
    drain();

    for (int i = 1; i < NR; i++) begin
      @(negedge clk);
      mregs[i] = DW'(i * 19'h1111 + 5);
      wr(i, mregs[i]);
      drain();
    end
    @(negedge clk); idle_in(); bus.sb_set = 1'b1; bus.sb_addr = 5'd9;
    drain();
    for (int i = 0; i < NR; i += 2) begin
      @(negedge clk); idle_in(); rd(i, i + 1);
      expect_v($sformatf("fill_r%0d", i), 0, 32'(mregs[i]));
      expect_v($sformatf("fill_r%0d", i + 1), 1, 32'(mregs[i + 1]));
      drain();
    end

    @(negedge clk); bus.clr_req = 1'b1;
    drain();
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk); idle_in(); rd(9, 9);
      if (c == 10) wr(2, 19'h00055);
      if (c == 11) wr(20, 19'h00777);
      expect_v($sformatf("clr_busy_c%0d", c), 4, (c < NR) ? 1 : 0);
      expect_v($sformatf("clr_done_c%0d", c), 5, (c == NR) ? 1 : 0);
      if (c == 0) expect_v("clr_pend9", 2, 0);
      #1;
      busy_cnt += int'(bus.clr_busy);
      done_cnt += int'(bus.clr_done);
      drain();
    end
    chk("busy_cycles", 32'(busy_cnt), 32);
    chk("done_pulses", 32'(done_cnt), 1);

    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mregs[2] = 19'h00055;
    for (int i = 0; i < NR; i += 2) begin
      @(negedge clk); rd(i, i + 1);
      expect_v($sformatf("clr_r%0d", i), 0, 32'(mregs[i]));
      expect_v($sformatf("clr_r%0d", i + 1), 1, 32'(mregs[i + 1]));
      drain();
    end

    for (int i = 1; i < 8; i++) begin
      @(negedge clk); wr(i, DW'(19'h33330 + i));
      drain();
    end
    @(negedge clk); idle_in(); bus.sb_set = 1'b1; bus.sb_addr = 5'd4;
    drain();
    @(negedge clk); idle_in(); bus.clr_req = 1'b1;
    drain();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); idle_in(); rd(20, 20);
      drain();
    end
    @(negedge clk); rst = 1'b1; rd(6, 7);
    expect_v("abort_busy", 4, 0);
    expect_v("abort_done", 5, 0);
    expect_v("abort_r6", 0, 0);
    expect_v("abort_r7", 1, 0);
    drain();
    @(negedge clk); rst = 1'b0;
    drain();
    for (int i = 0; i < NR; i += 2) begin
      @(negedge clk); rd(i, i + 1);
      expect_v($sformatf("abort_r%0d", i), 0, 0);
      expect_v($sformatf("abort_p%0d", i + 1), 3, 0);
      expect_v("abort_nodone", 5, 0);
      drain();
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      expect_v("abort_quiet", 5, 0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
